// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher: issues word fetches under a credit limit, buffers
// in-order responses with their PCs, and drops responses made stale by a PC redirect.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   resp_pc_reg, resp_pc_next;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [CW-1:0] discard_reg, discard_next;
  logic [CW-1:0] fifo_count_reg, fifo_count_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;

  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  logic [CW:0]  credit_sum;
  logic [31:0]  redirect_aligned;
  logic         req_fire;
  logic         resp_live;
  logic         push;
  logic         pop;

  assign redirect_aligned = redirect_pc & ~32'h3;
  assign credit_sum       = {1'b0, outstanding_reg} + {1'b0, fifo_count_reg};

  // Live reset gating keeps the request line quiet while reset is held.
  assign mem_req_valid = reset && !halt && !redirect_valid && (credit_sum < DEPTH_W);
  assign mem_req_addr  = fetch_pc_reg;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // A response with nothing outstanding is ignored so the counters cannot underflow.
  assign resp_live = mem_resp_valid && (outstanding_reg != '0);
  assign push      = resp_live && !redirect_valid && (discard_reg == '0);

  assign out_valid = (fifo_count_reg != '0) && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign out_inst  = (fifo_count_reg != '0) ? inst_mem[rd_ptr_reg] : 32'h0;
  assign out_pc    = (fifo_count_reg != '0) ? pc_mem[rd_ptr_reg]   : 32'h0;

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    outstanding_next = outstanding_reg;
    discard_next     = discard_reg;
    fifo_count_next  = fifo_count_reg;
    rd_ptr_next      = rd_ptr_reg;
    wr_ptr_next      = wr_ptr_reg;

    if (req_fire && !resp_live) begin
      outstanding_next = outstanding_reg + CW'(1);
    end else if (!req_fire && resp_live) begin
      outstanding_next = outstanding_reg - CW'(1);
    end

    if (redirect_valid) begin
      fetch_pc_next   = redirect_aligned;
      resp_pc_next    = redirect_aligned;
      fifo_count_next = '0;
      rd_ptr_next     = '0;
      wr_ptr_next     = '0;
      // Everything still in flight after this edge predates the redirect.
      discard_next    = resp_live ? outstanding_reg - CW'(1) : outstanding_reg;
    end else begin
      if (req_fire) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
      end
      if (resp_live && (discard_reg != '0)) begin
        discard_next = discard_reg - CW'(1);
      end
      if (push) begin
        resp_pc_next = resp_pc_reg + 32'd4;
        wr_ptr_next  = wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      if (push && !pop) begin
        fifo_count_next = fifo_count_reg + CW'(1);
      end else if (!push && pop) begin
        fifo_count_next = fifo_count_reg - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      fifo_count_reg  <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      fifo_count_reg  <= fifo_count_next;
      rd_ptr_reg      <= rd_ptr_next;
      wr_ptr_reg      <= wr_ptr_next;
    end
  end

  // Storage needs no reset: entries are only visible while fifo_count is nonzero.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      inst_mem[wr_ptr_reg] <= mem_resp_data;
      pc_mem[wr_ptr_reg]   <= resp_pc_reg;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: in-order variable-latency memory, a queue-based model of
// the expected output stream, a per-cycle compare process, and directed scenarios.
module tb_fetch_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        reset;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          ep;
    int          due;
  } req_t;

  req_t        memq[$];
  logic [31:0] fq[$];
  logic [31:0] popped[$];
  logic [31:0] exp_fetch, exp_pop;
  int          epoch, cyc, n_accept, lat_fixed;
  bit          rand_mode;
  int          tests, fails;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: responds in order once the head request's latency has elapsed.
  always @(posedge clk) begin
    #1;
    cyc++;
    mem_req_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = memq[0].data;
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = $urandom;
    end
  end

  // Model and per-cycle comparison; inputs are stable from posedge+1 to the next posedge.
  always @(negedge clk) begin
    req_t r;
    if (!reset) begin
      memq.delete();
      fq.delete();
      exp_fetch = RESET_PC;
      exp_pop   = RESET_PC;
      epoch++;
    end else begin
      chk("req_valid", {31'b0, mem_req_valid},
          {31'b0, (!halt && !redirect_valid && (memq.size() + fq.size() < DEPTH))});
      if (mem_req_valid) chk("req_addr", mem_req_addr, exp_fetch);
      chk("out_valid", {31'b0, out_valid}, {31'b0, (fq.size() != 0 && !redirect_valid)});
      if (out_valid && fq.size() > 0) begin
        chk("out_pc", out_pc, fq[0]);
        chk("out_inst", out_inst, memf(fq[0]));
      end
      if (out_valid && out_ready) begin
        chk("seq_pc", out_pc, exp_pop);
        popped.push_back(out_pc);
        exp_pop += 32'd4;
        if (fq.size() > 0) void'(fq.pop_front());
      end
      if (mem_resp_valid && memq.size() > 0) begin
        r = memq.pop_front();
        if (r.ep == epoch && !redirect_valid) fq.push_back(r.pc);
      end
      if (mem_req_valid && mem_req_ready) begin
        r.pc   = exp_fetch;
        r.data = memf(mem_req_addr);
        r.ep   = epoch;
        r.due  = cyc + (rand_mode ? int'($urandom_range(1, 5)) : lat_fixed);
        memq.push_back(r);
        exp_fetch += 32'd4;
        n_accept++;
      end
      if (redirect_valid) begin
        fq.delete();
        epoch++;
        exp_fetch = {redirect_pc[31:2], 2'b00};
        exp_pop   = exp_fetch;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0; out_ready = 1'b1;
    rand_mode = 1'b0;
    step(2);
    chk("rst_req_valid", {31'b0, mem_req_valid}, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_req_addr", mem_req_addr, RESET_PC);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    reset = 1'b1;
    popped.delete();
    n_accept = 0;
  endtask

  task automatic wait_accepts(input int n, input string name);
    int k;
    k = 0;
    while (n_accept < n && k < 50) begin step(1); k++; end
    chk(name, {31'b0, (n_accept >= n)}, 32'h1);
  endtask

  initial begin
    int k;
    bit found, mid;
    tests = 0; fails = 0; cyc = 0; epoch = 0; lat_fixed = 1;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;

    // 1: latency 1, continuous streaming
    lat_fixed = 1;
    do_reset();
    step(1);
    chk("t1_not_yet", {31'b0, out_valid}, 32'h0);
    step(1);
    chk("t1_first_valid", {31'b0, out_valid}, 32'h1);
    chk("t1_first_pc", out_pc, 32'h0);
    chk("t1_first_inst", out_inst, 32'h1234_5678);
    step(10);
    chk("t1_pop_count", popped.size(), 32'd10);
    if (popped.size() >= 5) chk("t1_pc4", popped[4], 32'h10);

    // 2: backpressure caps requests at DEPTH
    do_reset();
    out_ready = 1'b0;
    step(20);
    chk("t2_accepts", n_accept, 32'd4);
    chk("t2_req_low", {31'b0, mem_req_valid}, 32'h0);
    out_ready = 1'b1;
    step(6);
    if (popped.size() >= 4) begin
      chk("t2_p0", popped[0], 32'h0);
      chk("t2_p1", popped[1], 32'h4);
      chk("t2_p2", popped[2], 32'h8);
      chk("t2_p3", popped[3], 32'hC);
    end else chk("t2_pop_count", popped.size(), 32'd4);

    // 3: latency 3, redirect with 0x8 and 0xC in flight
    lat_fixed = 3;
    do_reset();
    wait_accepts(4, "t3_issue");
    halt = 1'b1;
    k = 0;
    while (!(memq.size() == 2 && memq[0].pc == 32'h8) && k < 20) begin step(1); k++; end
    chk("t3_inflight", {31'b0, (memq.size() == 2)}, 32'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h103; halt = 1'b0;
    step(1);
    redirect_valid = 1'b0;
    step(20);
    if (popped.size() >= 3) begin
      chk("t3_p0", popped[0], 32'h0);
      chk("t3_p1", popped[1], 32'h100);
      chk("t3_p2", popped[2], 32'h104);
    end else chk("t3_pop_count", popped.size(), 32'd3);

    // 4: back-to-back redirects, responses arriving on both
    lat_fixed = 2;
    do_reset();
    step(6);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step(1);
    redirect_pc = 32'h80;
    step(1);
    redirect_valid = 1'b0;
    step(15);
    found = 1'b0; mid = 1'b0;
    foreach (popped[i]) begin
      if (popped[i] == 32'h80) found = 1'b1;
      if (popped[i] >= 32'h40 && popped[i] < 32'h80) mid = 1'b1;
    end
    chk("t4_new_pc_seen", {31'b0, found}, 32'h1);
    chk("t4_no_stale", {31'b0, mid}, 32'h0);
    halt = 1'b1;
    step(10);
    chk("t4_idle", {31'b0, out_valid}, 32'h0);
    halt = 1'b0;
    step(10);

    // 5: halt with two in flight
    lat_fixed = 3;
    do_reset();
    wait_accepts(2, "t5_issue");
    halt = 1'b1;
    step(10);
    chk("t5_accepts", n_accept, 32'd2);
    chk("t5_pops", popped.size(), 32'd2);
    halt = 1'b0;
    step(10);
    if (popped.size() >= 3) chk("t5_resume", popped[2], 32'h8);
    else chk("t5_pop_count", popped.size(), 32'd3);

    // 6: random traffic, redirects, halts and backpressure
    do_reset();
    rand_mode = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      redirect_valid = ($urandom_range(0, 99) < 3);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                                   : $urandom;
      halt           = ($urandom_range(0, 99) < 5);
      out_ready      = 1'($urandom_range(0, 1));
      step(1);
    end
    rand_mode = 1'b0; redirect_valid = 1'b0; halt = 1'b0; out_ready = 1'b1;
    step(40);
    chk("t6_progress", {31'b0, (popped.size() > 100)}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
